mdl_pageseq: RTL

Bubble page-read sequencer that drives the sync-pattern detector and turns the raw bubble input stream into a framed page. On a start request it arms the detector, hunts for the sync tip under a timeout with bounded retries, then counts out a fixed-length page, presenting one data bit per 2 MHz tick. It sits between the host-side page request logic and the sync detector/bubble data path, owning the detector's `i_BSEN_n` and `i_GLCNT_RD` controls.

---
 rtl/mdl_pageseq.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mdl_pageseq.sv
// mdl_pageseq: bubble page-read sequencer; arms the sync detector, hunts for the
//   sync tip under a timeout with bounded retries, then frames PAGE_BITS data bits.
// Latency: start->busy/shift-enable 1 tick, sync tip->first data bit 1 tick, last bit->done 1 tick.
// Backpressure: none; the page streams at one bit per enabled 2 MHz tick and abort is the only throttle.
//
// Ports:
//   i_MCLK          master clock
//   i_RST           synchronous active-high reset; acts on every i_MCLK edge, even when the enable is high
//   i_CLK2M_PCEN_n  2 MHz clock enable, active-low; all state and outputs advance only when low
//   i_START         page-read request level, honoured only in IDLE
//   i_ABORT         cancel the current operation (back to IDLE on the next enabled tick)
//   i_SYNCTIP_n     sync tip from the detector, active-low
//   i_BDI           raw bubble data bit
//   o_BSEN_n        detector shift enable, active-low
//   o_GLCNT_RD      detector good-loop count/advance
//   o_BUSY          high whenever the sequencer is not idle
//   o_DATA          page bit, qualified by o_DATA_VALID
//   o_DATA_VALID    one-tick strobe per page bit
//   o_DONE          one-tick pulse at page end
//   o_ERR           sticky failure flag, cleared by the next accepted start
//   o_RETRY_CNT     hunt attempts used for the current or last page
//
// Build option: define PAGESEQ_CRC_EN to check a CRC-16-CCITT (0x1021, init 0xFFFF,
//   MSB-first) over the whole page; the last 16 page bits carry the CRC, and a nonzero
//   residue at page end raises o_ERR together with o_DONE.
//
// Output timing: each registered output reflects the state the sequencer occupied at
// the enabled edge that loaded it, so e.g. the ARM tick's shift enable appears one tick
// after the start was accepted, and the DONE pulse one tick after the last data bit.

module mdl_pageseq #(
  parameter int PAGE_BITS = 512,
  parameter int TIMEOUT   = 4096,
  parameter int RETRY_MAX = 3
) (
  input  logic       i_MCLK,
  input  logic       i_RST,
  input  logic       i_CLK2M_PCEN_n,
  input  logic       i_START,
  input  logic       i_ABORT,
  input  logic       i_SYNCTIP_n,
  input  logic       i_BDI,
  output logic       o_BSEN_n,
  output logic       o_GLCNT_RD,
  output logic       o_BUSY,
  output logic       o_DATA,
  output logic       o_DATA_VALID,
  output logic       o_DONE,
  output logic       o_ERR,
  output logic [1:0] o_RETRY_CNT
);

  // Timeout counter is sized to hold TIMEOUT-1; a TIMEOUT of 1 still needs one bit.
  localparam int              TO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [15:0]     BIT_LAST  = 16'(PAGE_BITS - 1);
  localparam logic [1:0]      RETRY_LIM = 2'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_HUNT,
    S_REARM,
    S_XFER,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_nxt;
  logic [15:0]     bit_cnt;
  logic [15:0]     bit_cnt_nxt;
  logic [1:0]      retry_nxt;
  logic            bsen_n_nxt;
  logic            glcnt_nxt;
  logic            busy_nxt;
  logic            data_nxt;
  logic            valid_nxt;
  logic            done_nxt;
  logic            err_nxt;
  logic            tick;
  logic            crc_bad;

  assign tick = ~i_CLK2M_PCEN_n;

`ifdef PAGESEQ_CRC_EN
  logic [15:0] crc;
  logic [15:0] crc_nxt;

  // One MSB-first CRC-16-CCITT step: feedback is the outgoing MSB xor the new bit.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Running the CRC over data plus its own appended CRC leaves a zero residue.
  always_comb begin
    crc_nxt = crc;
    if (state == S_ARM) begin
      crc_nxt = 16'hFFFF;
    end else if (state == S_XFER) begin
      crc_nxt = crc_step(crc, i_BDI);
    end
  end

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      crc <= 16'hFFFF;
    end else if (tick) begin
      crc <= crc_nxt;
    end
  end

  assign crc_bad = (crc != 16'h0000);
`else
  assign crc_bad = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    to_cnt_nxt  = to_cnt;
    bit_cnt_nxt = bit_cnt;
    retry_nxt   = o_RETRY_CNT;
    bsen_n_nxt  = 1'b1;
    glcnt_nxt   = 1'b0;
    busy_nxt    = (state != S_IDLE);
    data_nxt    = o_DATA;
    valid_nxt   = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = o_ERR;

    case (state)
      S_IDLE: begin
        if (i_START) begin
          state_nxt  = S_ARM;
          err_nxt    = 1'b0;
          retry_nxt  = 2'd0;
          to_cnt_nxt = '0;
        end
      end

      S_ARM: begin
        bsen_n_nxt = 1'b0;
        retry_nxt  = o_RETRY_CNT + 2'd1;
        state_nxt  = S_HUNT;
      end

      S_HUNT: begin
        bsen_n_nxt = 1'b0;
        glcnt_nxt  = 1'b1;
        to_cnt_nxt = to_cnt + 1'b1;
        // Sync tip is tested first so it wins over a coincident timeout.
        if (!i_SYNCTIP_n) begin
          state_nxt   = S_XFER;
          bit_cnt_nxt = '0;
        end else if (to_cnt == TO_LAST) begin
          to_cnt_nxt = '0;
          if (o_RETRY_CNT < RETRY_LIM) begin
            state_nxt = S_REARM;
          end else begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
          end
        end
      end

      // Shift enable goes high for one tick so the detector drops its zero-bit count.
      S_REARM: begin
        to_cnt_nxt = '0;
        state_nxt  = S_ARM;
      end

      S_XFER: begin
        bsen_n_nxt  = 1'b0;
        glcnt_nxt   = 1'b1;
        data_nxt    = i_BDI;
        valid_nxt   = 1'b1;
        bit_cnt_nxt = bit_cnt + 16'd1;
        if (bit_cnt == BIT_LAST) begin
          state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        done_nxt  = 1'b1;
        err_nxt   = o_ERR | crc_bad;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides sync tip, timeout and page end; outputs drop straight to idle
    // values and the error flag is left untouched.
    if (i_ABORT && (state != S_IDLE)) begin
      state_nxt  = S_IDLE;
      bsen_n_nxt = 1'b1;
      glcnt_nxt  = 1'b0;
      busy_nxt   = 1'b0;
      data_nxt   = o_DATA;
      valid_nxt  = 1'b0;
      done_nxt   = 1'b0;
      err_nxt    = o_ERR;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state        <= S_IDLE;
      to_cnt       <= '0;
      bit_cnt      <= '0;
      o_BSEN_n     <= 1'b1;
      o_GLCNT_RD   <= 1'b0;
      o_BUSY       <= 1'b0;
      o_DATA       <= 1'b0;
      o_DATA_VALID <= 1'b0;
      o_DONE       <= 1'b0;
      o_ERR        <= 1'b0;
      o_RETRY_CNT  <= 2'd0;
    end else if (tick) begin
      state        <= state_nxt;
      to_cnt       <= to_cnt_nxt;
      bit_cnt      <= bit_cnt_nxt;
      o_BSEN_n     <= bsen_n_nxt;
      o_GLCNT_RD   <= glcnt_nxt;
      o_BUSY       <= busy_nxt;
      o_DATA       <= data_nxt;
      o_DATA_VALID <= valid_nxt;
      o_DONE       <= done_nxt;
      o_ERR        <= err_nxt;
      o_RETRY_CNT  <= retry_nxt;
    end
  end

endmodule
